// File: rtl/brstat_pkg.sv
// Shared defaults and the snapshot bundle for the branch statistics block.
// Optional feature macro: BRSTAT_MISPRED_EN adds the mispredict field.
package brstat_pkg;

   localparam int CNT_W_DEF       = 32;
   localparam int SNAP_W_DEF      = 16;
   localparam int SNAP_PERIOD_DEF = 25_000_000;

   // Fields are sized to the default snapshot width; narrower snapshots are
   // zero-extended into them and sliced back out at the ports.
   typedef struct packed {
      logic [SNAP_W_DEF-1:0] branches;
      logic [SNAP_W_DEF-1:0] taken;
`ifdef BRSTAT_MISPRED_EN
      logic [SNAP_W_DEF-1:0] mispred;
`endif
   } brstat_snap_t;

endpackage

// File: rtl/brstat_sat_counter.sv
// W-bit saturating up-counter with synchronous clear priority.
// sat_hit flags an increment attempted while already at all-ones.
module brstat_sat_counter
   import brstat_pkg::*;
#(
   parameter int W = CNT_W_DEF
) (
   input  logic         clk,
   input  logic         rstn,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] cnt,
   output logic         sat_hit
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;
   logic         at_max;

   assign at_max  = &cnt_q;
   assign sat_hit = inc & at_max;
   assign cnt     = cnt_q;

   // Next count: clear wins, otherwise step unless already saturated.
   always_comb begin
      // NOTE: defaulting every always_comb output first keeps a missed branch from inferring a latch.
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (inc && !at_max) begin
         cnt_d = cnt_q + W'(1);
      end
   end

   // Count register with synchronous active-low reset.
   always_ff @(posedge clk) begin
      // NOTE: state registers use <= so every flop samples pre-edge values regardless of block order.
      if (!rstn) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/branch_stat_counter.sv
// Retired / taken branch counters with periodic low-bit snapshots for the
// seven-segment display path (clk_core domain).
// Optional feature macro: BRSTAT_MISPRED_EN adds a mispredict counter.
module branch_stat_counter
   import brstat_pkg::*;
#(
   parameter int CNT_W       = CNT_W_DEF,
   parameter int SNAP_W      = SNAP_W_DEF,
   parameter int SNAP_PERIOD = SNAP_PERIOD_DEF
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              i_br_valid,
   input  logic              i_br_taken,
`ifdef BRSTAT_MISPRED_EN
   input  logic              i_br_mispred,
`endif
   input  logic              i_clear,
   input  logic              i_freeze,
   output logic [CNT_W-1:0]  o_branches,
   output logic [CNT_W-1:0]  o_taken,
   output logic [SNAP_W-1:0] o_snap_branches,
   output logic [SNAP_W-1:0] o_snap_taken,
   output logic              o_snap_stb,
`ifdef BRSTAT_MISPRED_EN
   output logic [CNT_W-1:0]  o_mispred,
   output logic [SNAP_W-1:0] o_snap_mispred,
`endif
   output logic              o_ovf
);

   localparam int TMR_W = $clog2(SNAP_PERIOD);

   if (SNAP_W > CNT_W || SNAP_W > SNAP_W_DEF || SNAP_PERIOD < 2) begin : g_bad_cfg
      $error("branch_stat_counter: illegal SNAP_W / CNT_W / SNAP_PERIOD combination");
   end

   logic             valid_q, valid_d;
   logic             taken_q, taken_d;
   logic [TMR_W-1:0] tmr_q, tmr_d;
   brstat_snap_t     snap_q, snap_d;
   logic             stb_q, stb_d;
   logic             ovf_q, ovf_d;
   logic             wrap;
   logic [CNT_W-1:0] cnt_br, cnt_tk;
   logic             sat_br, sat_tk, sat_any;
`ifdef BRSTAT_MISPRED_EN
   logic             mispred_q, mispred_d;
   logic [CNT_W-1:0] cnt_mp;
   logic             sat_mp;
`endif

   brstat_sat_counter #(.W(CNT_W)) u_cnt_br (
      .clk(clk), .rstn(rstn), .clr(i_clear), .inc(valid_q), .cnt(cnt_br), .sat_hit(sat_br)
   );

   brstat_sat_counter #(.W(CNT_W)) u_cnt_tk (
      .clk(clk), .rstn(rstn), .clr(i_clear), .inc(taken_q), .cnt(cnt_tk), .sat_hit(sat_tk)
   );

`ifdef BRSTAT_MISPRED_EN
   brstat_sat_counter #(.W(CNT_W)) u_cnt_mp (
      .clk(clk), .rstn(rstn), .clr(i_clear), .inc(mispred_q), .cnt(cnt_mp), .sat_hit(sat_mp)
   );
   assign sat_any = sat_br | sat_tk | sat_mp;
`else
   assign sat_any = sat_br | sat_tk;
`endif

   assign wrap = (tmr_q == TMR_W'(SNAP_PERIOD - 1));

   // Next state: input stage, period timer, snapshot capture, sticky overflow; clear overrides all.
   always_comb begin
      valid_d = i_br_valid;
      taken_d = i_br_valid & i_br_taken;
`ifdef BRSTAT_MISPRED_EN
      mispred_d = i_br_valid & i_br_mispred;
`endif
      tmr_d   = wrap ? '0 : tmr_q + TMR_W'(1);
      snap_d  = snap_q;
      stb_d   = 1'b0;
      ovf_d   = ovf_q | sat_any;

      // Capture uses the counts before this edge's increment lands.
      if (wrap && !i_freeze) begin
         snap_d.branches = SNAP_W_DEF'(cnt_br[SNAP_W-1:0]);
         snap_d.taken    = SNAP_W_DEF'(cnt_tk[SNAP_W-1:0]);
`ifdef BRSTAT_MISPRED_EN
         snap_d.mispred  = SNAP_W_DEF'(cnt_mp[SNAP_W-1:0]);
`endif
         stb_d           = 1'b1;
      end

      if (i_clear) begin
         valid_d = 1'b0;
         taken_d = 1'b0;
`ifdef BRSTAT_MISPRED_EN
         mispred_d = 1'b0;
`endif
         tmr_d   = '0;
         snap_d  = '0;
         stb_d   = 1'b0;
         ovf_d   = 1'b0;
      end
   end

   // Registered state with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         valid_q <= 1'b0;
         taken_q <= 1'b0;
`ifdef BRSTAT_MISPRED_EN
         mispred_q <= 1'b0;
`endif
         tmr_q   <= '0;
         snap_q  <= '0;
         stb_q   <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         valid_q <= valid_d;
         taken_q <= taken_d;
`ifdef BRSTAT_MISPRED_EN
         mispred_q <= mispred_d;
`endif
         tmr_q   <= tmr_d;
         snap_q  <= snap_d;
         stb_q   <= stb_d;
         ovf_q   <= ovf_d;
      end
   end

   assign o_branches      = cnt_br;
   assign o_taken         = cnt_tk;
   assign o_snap_branches = snap_q.branches[SNAP_W-1:0];
   assign o_snap_taken    = snap_q.taken[SNAP_W-1:0];
   assign o_snap_stb      = stb_q;
   assign o_ovf           = ovf_q;
`ifdef BRSTAT_MISPRED_EN
   assign o_mispred       = cnt_mp;
   assign o_snap_mispred  = snap_q.mispred[SNAP_W-1:0];
`endif

endmodule

// File: tb/tb_branch_stat_counter.sv
// Directed bench for branch_stat_counter. Two instances share stimulus:
// dut (CNT_W=8, SNAP_W=4) and dut_sat (CNT_W=4, SNAP_W=4), both SNAP_PERIOD=8.
// Optional feature macro: BRSTAT_MISPRED_EN enables the mispredict section.
module tb_branch_stat_counter;

   logic clk;
   logic rstn;
   logic br_valid, br_taken, clear, freeze;
`ifdef BRSTAT_MISPRED_EN
   logic br_mispred;
   logic [7:0] mispred;
   logic [3:0] snap_mispred;
   logic [3:0] s_mispred;
   logic [3:0] s_snap_mispred;
`endif

   logic [7:0] branches, taken;
   logic [3:0] snap_branches, snap_taken;
   logic       snap_stb, ovf;
   logic [3:0] s_branches, s_taken, s_snap_branches, s_snap_taken;
   logic       s_snap_stb, s_ovf;

   int n_checks = 0;
   int n_pass   = 0;
   int pulses;

   branch_stat_counter #(.CNT_W(8), .SNAP_W(4), .SNAP_PERIOD(8)) dut (
      .clk(clk), .rstn(rstn), .i_br_valid(br_valid), .i_br_taken(br_taken),
`ifdef BRSTAT_MISPRED_EN
      .i_br_mispred(br_mispred),
`endif
      .i_clear(clear), .i_freeze(freeze),
      .o_branches(branches), .o_taken(taken),
      .o_snap_branches(snap_branches), .o_snap_taken(snap_taken),
      .o_snap_stb(snap_stb),
`ifdef BRSTAT_MISPRED_EN
      .o_mispred(mispred), .o_snap_mispred(snap_mispred),
`endif
      .o_ovf(ovf)
   );

   branch_stat_counter #(.CNT_W(4), .SNAP_W(4), .SNAP_PERIOD(8)) dut_sat (
      .clk(clk), .rstn(rstn), .i_br_valid(br_valid), .i_br_taken(br_taken),
`ifdef BRSTAT_MISPRED_EN
      .i_br_mispred(br_mispred),
`endif
      .i_clear(clear), .i_freeze(freeze),
      .o_branches(s_branches), .o_taken(s_taken),
      .o_snap_branches(s_snap_branches), .o_snap_taken(s_snap_taken),
      .o_snap_stb(s_snap_stb),
`ifdef BRSTAT_MISPRED_EN
      .o_mispred(s_mispred), .o_snap_mispred(s_snap_mispred),
`endif
      .o_ovf(s_ovf)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // One clock edge with the given strobes; returns 1 time unit after the edge.
   task automatic drive(input logic v, input logic t);
      br_valid = v;
      br_taken = t;
      @(posedge clk);
      #1;
   endtask

   initial begin
      rstn = 1'b0; br_valid = 1'b0; br_taken = 1'b0; clear = 1'b0; freeze = 1'b0;
`ifdef BRSTAT_MISPRED_EN
      br_mispred = 1'b0;
`endif

      // Reset held 3 cycles while strobing.
      for (int i = 0; i < 3; i++) drive(1'b1, 1'b1);
      check("rst_branches", branches, 0);
      check("rst_taken", taken, 0);
      check("rst_snap", snap_branches, 0);
      check("rst_stb", snap_stb, 0);
      check("rst_ovf", ovf, 0);
      rstn = 1'b1;
      drive(1'b1, 1'b0);
      check("lat_edge1", branches, 0);
      drive(1'b0, 1'b0);
      check("lat_edge2", branches, 1);

      // Counting: 10 strobes, 4 taken, then 3 taken-only without valid.
      clear = 1'b1; drive(1'b0, 1'b0); clear = 1'b0;
      check("clr_branches", branches, 0);
      for (int i = 0; i < 10; i++) drive(1'b1, (i % 3) == 0);
      for (int i = 0; i < 3; i++) drive(1'b0, 1'b1);
      check("cnt_branches", branches, 10);
      check("cnt_taken", taken, 4);

      // Snapshot: timer re-aligned by clear; wrap lands on edge 8.
      clear = 1'b1; drive(1'b0, 1'b0); clear = 1'b0;
      check("clr_snap", snap_branches, 0);
      drive(1'b1, 1'b1);
      drive(1'b1, 1'b1);
      drive(1'b1, 1'b0);
      drive(1'b1, 1'b0);
      drive(1'b1, 1'b0);
      drive(1'b0, 1'b0);
      drive(1'b1, 1'b0);                      // edge 7: strobe lands in the wrap cycle
      check("pre_wrap_stb", snap_stb, 0);
      check("pre_wrap_branches", branches, 5);
      drive(1'b0, 1'b0);                      // edge 8: wrap
      check("wrap_stb", snap_stb, 1);
      check("wrap_snap_branches", snap_branches, 5);
      check("wrap_snap_taken", snap_taken, 2);
      check("wrap_branches", branches, 6);
      drive(1'b0, 1'b0);                      // edge 9
      check("post_wrap_stb", snap_stb, 0);

      // Freeze across wraps at edges 16 and 24; live counters keep going.
      freeze = 1'b1;
      pulses = 0;
      for (int k = 10; k <= 25; k++) begin
         drive(1'b1, 1'b0);
         if (snap_stb) pulses++;
      end
      check("frz_pulses", pulses, 0);
      check("frz_snap_hold", snap_branches, 5);
      check("frz_live", branches, 21);
      freeze = 1'b0;
      drive(1'b0, 1'b0);                      // edge 26: no capture on release
      check("unfrz_no_stb", snap_stb, 0);
      check("unfrz_snap_hold", snap_branches, 5);
      check("unfrz_live", branches, 22);
      for (int k = 27; k <= 31; k++) drive(1'b0, 1'b0);
      drive(1'b0, 1'b0);                      // edge 32: wrap, 22 -> low nibble 6
      check("rewrap_stb", snap_stb, 1);
      check("rewrap_snap_low_bits", snap_branches, 6);
      check("rewrap_snap_taken", snap_taken, 2);
      check("sat_snap_saturated", s_snap_branches, 15);
      check("sat_ovf_sticky", s_ovf, 1);

      // Saturation on the 4-bit instance: clear with a strobe, then 17 strobes.
      clear = 1'b1; drive(1'b1, 1'b0); clear = 1'b0;
      check("sat_clr_branches", s_branches, 0);
      check("sat_clr_ovf", s_ovf, 0);
      for (int k = 1; k <= 17; k++) begin
         drive(1'b1, 1'b0);
         if (k == 16) begin
            check("sat_at_max", s_branches, 15);
            check("sat_no_ovf_yet", s_ovf, 0);
         end
      end
      drive(1'b0, 1'b0);                      // edge 18
      check("sat_hold", s_branches, 15);
      check("sat_ovf", s_ovf, 1);
      check("wide_branches", branches, 17);
      check("wide_no_ovf", ovf, 0);
      for (int k = 19; k <= 23; k++) drive(1'b0, 1'b0);
      clear = 1'b1; drive(1'b1, 1'b0); clear = 1'b0;   // edge 24: clear in a wrap cycle
      check("clr_wrap_stb", s_snap_stb, 0);
      check("clr_wrap_ovf", s_ovf, 0);
      check("clr_wrap_branches", s_branches, 0);
      check("clr_wrap_snap", s_snap_branches, 0);
      drive(1'b0, 1'b0);
      check("clr_strobe_dropped", s_branches, 0);

      // Mid-operation reset drops pending events and timer progress.
      drive(1'b1, 1'b0);
      drive(1'b1, 1'b0);
      rstn = 1'b0; drive(1'b0, 1'b0); rstn = 1'b1;
      check("mid_rst_branches", branches, 0);
      for (int k = 1; k <= 3; k++) drive(1'b1, 1'b0);
      for (int k = 4; k <= 7; k++) drive(1'b0, 1'b0);
      check("mid_rst_no_early_stb", snap_stb, 0);
      drive(1'b0, 1'b0);
      check("mid_rst_wrap_stb", snap_stb, 1);
      check("mid_rst_snap", snap_branches, 3);

`ifdef BRSTAT_MISPRED_EN
      // Mispredict counter: 6 branches, 2 mispredicted, one unqualified mispredict.
      clear = 1'b1; drive(1'b0, 1'b0); clear = 1'b0;
      for (int k = 1; k <= 6; k++) begin
         br_mispred = (k == 2) || (k == 5);
         drive(1'b1, 1'b0);
      end
      br_mispred = 1'b1;
      drive(1'b0, 1'b0);                      // edge 7
      br_mispred = 1'b0;
      check("mp_live", mispred, 2);
      drive(1'b0, 1'b0);                      // edge 8: wrap
      check("mp_snap", snap_mispred, 2);
      check("mp_snap_branches", snap_branches, 6);
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/branch_stat_counter.md
Name: branch_stat_counter

Overview:
- Counts retired branches and retired taken branches from the core's branch-retire strobes.
- Periodically captures the low 16 bits of each count into snapshot registers. These feed the seven-segment scan logic on the Nexys A7 top level, as branches_counter and branches_taken_counter nibbles.
- Sits between the core's branch-retire outputs and the display multiplexer, in the clk_core domain.

Parameters:
- CNT_W, 32, width of the live counters.
- SNAP_W, 16, width of the snapshot outputs sent to the display. Must be ≤ CNT_W.
- SNAP_PERIOD, 25000000, clk cycles between snapshot captures. Must be ≥ 2.

Ports:
- clk  in  1  core clock (clk_core).
- rstn  in  1  synchronous active-low reset.
- i_br_valid  in  1  a branch retired this cycle.
- i_br_taken  in  1  the retired branch was taken. Qualified by i_br_valid.
- i_clear  in  1  single-cycle synchronous clear of counters, snapshots and overflow flag.
- i_freeze  in  1  level signal; while high, snapshots are not updated.
- o_branches  out  CNT_W  live retired-branch count.
- o_taken  out  CNT_W  live taken-branch count.
- o_snap_branches  out  SNAP_W  last captured o_branches[SNAP_W-1:0].
- o_snap_taken  out  SNAP_W  last captured o_taken[SNAP_W-1:0].
- o_snap_stb  out  1  one-cycle pulse when a snapshot is captured.
- o_ovf  out  1  sticky flag: a counter has saturated.

Behaviour:
- Reset:
  - Sampled on posedge clk while rstn=0. Synchronous, no asynchronous path.
  - All outputs, the input register stage and the period timer reset to 0.
- Input stage:
  - i_br_valid and i_br_taken are registered once.
  - taken_q is defined as i_br_valid & i_br_taken. i_br_taken alone is ignored.
  - Total latency from strobe to o_branches/o_taken change: 2 cycles. Input is registered at edge N; the counter updates at edge N+1.
- Counters:
  - Each counter increments by 1 per registered event.
  - Counters saturate at all-ones and do not wrap.
  - An increment attempt at all-ones sets o_ovf. o_ovf holds until i_clear or reset.
- i_clear priority:
  - i_clear has priority over any same-cycle increment. Counters, snapshots, o_ovf, the timer and the input stage all go to 0.
  - o_snap_stb is forced to 0 in that cycle.
- Period timer:
  - Counts 0..SNAP_PERIOD-1, then wraps to 0.
  - At the wrap cycle, if i_freeze=0, the snapshot registers take the low SNAP_W bits of the counters as they stand before that cycle's increment. o_snap_stb=1 for exactly that cycle.
  - If i_freeze=1 at the wrap cycle, snapshots hold, o_snap_stb stays 0, and the timer still wraps. No capture is deferred.
- Freeze:
  - i_freeze does not stop the live counters.
  - Deasserting freeze causes no immediate capture. The next capture happens at the next wrap.
- Simultaneous events:
  - An event at the same edge as a capture is counted, but is not included in that snapshot.
- Reset mid-operation: all partial timer progress and pending registered events are discarded.

Optional Feature:
- Macro: BRSTAT_MISPRED_EN.
- When defined:
  - Adds input i_br_mispred (1, qualified by i_br_valid).
  - Adds output o_mispred (CNT_W) and o_snap_mispred (SNAP_W).
  - These use the same register stage, saturation, o_ovf contribution, clear and snapshot rules as the other counters.
- When undefined: these ports and the related logic do not exist, and behaviour is otherwise identical.

Decomposition:
- Package brstat_pkg holds:
  - CNT_W and SNAP_W default localparams.
  - SNAP_PERIOD default.
  - A typedef for the snapshot bundle: struct with branches, taken, and optionally mispred, each SNAP_W wide.
- Sub-module brstat_sat_counter is natural, instantiated two or three times.
  - Ports: clk, rstn, clr, inc, cnt[W-1:0], sat_hit.
  - Behaviour: a W-bit saturating counter with clear priority.

Test Plan:
- Reset: hold rstn=0 for 3 cycles while strobing i_br_valid=1 -> all outputs 0; first count appears 2 cycles after release with strobe.
- Counting: 10 valid strobes, of which 4 are taken, plus 3 cycles of i_br_taken=1 with valid=0 -> o_branches=10, o_taken=4.
- Snapshot (SNAP_PERIOD=8): 5 branches before the wrap, plus a strobe in the wrap cycle -> o_snap_branches=5, o_snap_stb high for 1 cycle; o_branches=6 afterwards.
- Freeze: i_freeze=1 across two wraps -> o_snap_stb never pulses and the snapshot holds its old value; live counters keep counting.
- Saturation (CNT_W=4): 17 strobes -> o_branches=15, o_ovf=1. Then i_clear together with a strobe -> everything 0 and o_ovf=0 on the next cycle.
- BRSTAT_MISPRED_EN: 6 branches, of which 2 are mispredicted -> o_mispred=2 and o_snap_mispred=2 after the next wrap.
